// File: rtl/spi_pkg.sv
// Shared SPI encodings: transfer-state codes from the state controller,
// the shift engine's internal FSM type and the default word length.
package spi_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic [2:0] ST_IDLE   = 3'b000;
    localparam logic [2:0] ST_REG_RD = 3'b001;
    localparam logic [2:0] ST_REG_WR = 3'b010;
    localparam logic [2:0] ST_DOUT   = 3'b011;
    localparam logic [2:0] ST_DIN    = 3'b100;

    typedef enum logic [1:0] {
        E_IDLE   = 2'd0,
        E_LOAD   = 2'd1,
        E_SHIFT  = 2'd2,
        E_FINISH = 2'd3
    } eng_state_t;

    // Codes 101..111 are reserved and behave like IDLE.
    function automatic logic is_active(input logic [2:0] s);
        return (s == ST_REG_RD) || (s == ST_REG_WR) || (s == ST_DOUT) || (s == ST_DIN);
    endfunction

endpackage

// File: rtl/spi_shift_engine_if.sv
// Controller <-> shift engine bundle, including the serial pins.
// slave = the shift engine, master = controller / SCK generator / pad side.
interface spi_shift_engine_if #(parameter int DATA_W = spi_pkg::DATA_W_DEF);
    logic [2:0]        state;
    logic              sck_rise;
    logic              sck_fall;
    logic [DATA_W-1:0] tx_data;
    logic              miso;
    logic              mosi;
    logic              cs_n;
    logic              sck_en;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;

    modport slave (
        input  state, sck_rise, sck_fall, tx_data, miso,
        output mosi, cs_n, sck_en, busy, done, rx_data, rx_valid
    );

    modport master (
        output state, sck_rise, sck_fall, tx_data, miso,
        input  mosi, cs_n, sck_en, busy, done, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_shift_engine_shift_reg.sv
// spi_shift_reg: parallel-load shift register with serial input and
// selectable direction. Load wins over shift.
module spi_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift,
    input  logic         lsb_first,
    input  logic         sin,
    output logic [W-1:0] q
);

    // Right shift for LSB-first (serial in at the MSB), else left shift.
    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= load_val;
        else if (shift)
            q <= lsb_first ? {sin, q[W-1:1]} : {q[W-2:0], sin};
    end

endmodule

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: SPI mode-0 bit engine. Serialises one word on MOSI,
// collects MISO, drives CS and emits a one-clk done pulse per word.
// Build option: define SPI_LSB_FIRST_EN for LSB-first shifting.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    localparam int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    spi_shift_engine_if.slave bus
);

`ifdef SPI_LSB_FIRST_EN
    localparam logic LSB_FIRST = 1'b1;
`else
    localparam logic LSB_FIRST = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    eng_state_t        cur, nxt;
    logic [CNT_W-1:0]  bit_cnt, cnt_d;
    logic [2:0]        mode_q, mode_d;
    logic              mosi_q, mosi_d, cs_n_q, cs_n_d, sck_en_q, sck_en_d;
    logic              busy_q, busy_d, done_q, done_d, rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [DATA_W-1:0] tx_q, rx_q;
    logic              tx_load, tx_shift, rx_shift;
    logic              active, rise, fall, tx_head, tx_after;

    assign active   = is_active(bus.state);
    assign rise     = bus.sck_rise;
    // A fall coincident with a rise is illegal; the rise takes precedence.
    assign fall     = bus.sck_fall & ~bus.sck_rise;
    assign tx_head  = LSB_FIRST ? tx_q[0] : tx_q[DATA_W-1];
    assign tx_after = LSB_FIRST ? tx_q[1] : tx_q[DATA_W-2];

    spi_shift_reg #(.W(DATA_W)) u_tx (
        .clk(clk), .rst(rst), .load(tx_load),
        .load_val((bus.state == ST_DIN) ? {DATA_W{1'b1}} : bus.tx_data),
        .shift(tx_shift), .lsb_first(LSB_FIRST), .sin(1'b0), .q(tx_q)
    );

    spi_shift_reg #(.W(DATA_W)) u_rx (
        .clk(clk), .rst(rst), .load(1'b0), .load_val({DATA_W{1'b0}}),
        .shift(rx_shift), .lsb_first(LSB_FIRST), .sin(bus.miso), .q(rx_q)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur        <= E_IDLE;
            bit_cnt    <= '0;
            mode_q     <= ST_IDLE;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            sck_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            cur        <= nxt;
            bit_cnt    <= cnt_d;
            mode_q     <= mode_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            sck_en_q   <= sck_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // Next state: abort to IDLE whenever the transfer state drops mid-word.
    always_comb begin
        nxt = cur;
        case (cur)
            E_IDLE:   if (active && !busy_q) nxt = E_LOAD;
            E_LOAD:   nxt = active ? E_SHIFT : E_IDLE;
            E_SHIFT: begin
                if (!active)
                    nxt = E_IDLE;
                else if (!rise && fall && bit_cnt == CNT_FULL)
                    nxt = E_FINISH;
            end
            E_FINISH: nxt = E_IDLE;
            default:  nxt = E_IDLE;
        endcase
    end

    // Output / datapath next values for each engine state.
    always_comb begin
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        sck_en_d   = sck_en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        cnt_d      = bit_cnt;
        mode_d     = mode_q;
        tx_load    = 1'b0;
        tx_shift   = 1'b0;
        rx_shift   = 1'b0;
        case (cur)
            E_IDLE: begin
                if (active && !busy_q) begin
                    tx_load = 1'b1;
                    mode_d  = bus.state;
                    cnt_d   = '0;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            E_LOAD, E_SHIFT: begin
                if (!active) begin
                    cs_n_d   = 1'b1;
                    sck_en_d = 1'b0;
                    busy_d   = 1'b0;
                    mosi_d   = 1'b0;
                end else if (cur == E_LOAD) begin
                    mosi_d   = tx_head;
                    sck_en_d = 1'b1;
                end else if (rise) begin
                    rx_shift = 1'b1;
                    cnt_d    = bit_cnt + CNT_W'(1);
                end else if (fall) begin
                    if (bit_cnt < CNT_FULL) begin
                        tx_shift = 1'b1;
                        mosi_d   = tx_after;
                    end else if (bit_cnt == CNT_FULL) begin
                        sck_en_d = 1'b0;
                    end
                end
            end
            E_FINISH: begin
                done_d = 1'b1;
                cs_n_d = 1'b1;
                busy_d = 1'b0;
                mosi_d = 1'b0;
                // Mode was latched at word start; DOUT words return no data.
                if (mode_q != ST_DOUT) begin
                    rx_data_d  = rx_q;
                    rx_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.mosi     = mosi_q;
    assign bus.cs_n     = cs_n_q;
    assign bus.sck_en   = sck_en_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

endmodule
